// File: rtl/hmat_alpha_stream_src_pkg.sv
// rtl/hmat_alpha_stream_src_pkg.sv - shared constants, state enum and width helpers
package hmat_alpha_stream_src_pkg;

  localparam int J_DEF = 14;
  localparam int I_DEF = 7;
  localparam int A_DEF = 2;
  localparam int W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    H_SEND,
    A_SEND,
    PAR_SEND,
    FRAME_END
  } state_t;

  function automatic int addr_w(input int i, input int a);
    return $clog2((i > a) ? i : a) + 1;
  endfunction

  // Index width never collapses to zero, even for single-entry buffers
  function automatic int idx_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/hmat_alpha_stream_src_if.sv
// rtl/hmat_alpha_stream_src_if.sv - H_row and alpha_u_col stream bundle
interface hmat_alpha_stream_src_if
  import hmat_alpha_stream_src_pkg::*;
#(
  parameter int J = J_DEF,
  parameter int W = W_DEF
);

  logic [J-1:0]   H_row;
  logic           H_row_tvalid;
  logic           H_row_tlast;
  logic           H_row_tready;
  logic [J*W-1:0] alpha_u_col;
  logic           alpha_u_col_tvalid;
  logic           alpha_u_col_tlast;
  logic           alpha_u_col_tready;

  modport master (
    output H_row, H_row_tvalid, H_row_tlast,
    output alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
    input  H_row_tready, alpha_u_col_tready
  );

  modport slave (
    input  H_row, H_row_tvalid, H_row_tlast,
    input  alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
    output H_row_tready, alpha_u_col_tready
  );

endinterface

// File: rtl/hmat_alpha_stream_src_beat_ctr.sv
// rtl/hmat_alpha_stream_src_beat_ctr.sv - per-stream beat index, valid and last tracking
module stream_beat_ctr
  import hmat_alpha_stream_src_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IW    = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          tready,
  output logic [IW-1:0] idx,
  output logic          tvalid,
  output logic          tlast,
  output logic          fin
);

  assign fin = tvalid && tready && tlast;

  // idx/tlast only move on a completed beat, so they hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (go) begin
      idx    <= '0;
      tvalid <= 1'b1;
      tlast  <= (DEPTH == 1);
    end else if (tvalid && tready) begin
      if (tlast) begin
        idx    <= '0;
        tvalid <= 1'b0;
        tlast  <= 1'b0;
      end else begin
        idx   <= idx + 1'b1;
        tlast <= (idx == IW'(DEPTH - 2));
      end
    end
  end

endmodule

// File: rtl/hmat_alpha_stream_src.sv
// rtl/hmat_alpha_stream_src.sv - reloadable H-row / alpha-column stimulus source with frame repeat
module hmat_alpha_stream_src
  import hmat_alpha_stream_src_pkg::*;
#(
  parameter int J  = J_DEF,
  parameter int I  = I_DEF,
  parameter int A  = A_DEF,
  parameter int W  = W_DEF,
  parameter int AW = addr_w(I, A)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [AW-1:0]    wr_addr,
  input  logic [J*W-1:0]   wr_data,
  output logic             wr_err,
  input  logic             start,
  input  logic             mode_par,
  input  logic [7:0]       n_frames,
  output logic             busy,
  output logic             done,
  hmat_alpha_stream_src_if.master strm
);

  localparam int HIW = idx_w(I);
  localparam int AIW = idx_w(A);

  logic [J-1:0]   h_buf [I];
  logic [J*W-1:0] a_buf [A];

  state_t         state, state_nx;
  logic           par_q;
  logic [7:0]     nf_q, nf_eff, frame_cnt;
  logic           h_go, a_go, h_fin, a_fin, last_frame, done_nx;
  logic           h_wr_ok, a_wr_ok, start_ok;
  logic [HIW-1:0] h_idx;
  logic [AIW-1:0] a_idx;
  logic           h_tvalid, h_tlast, a_tvalid, a_tlast;
  logic [J-1:0]   h_data;
  logic [J*W-1:0] a_data;

  assign start_ok   = (state == IDLE) && start;
  assign nf_eff     = (nf_q == 8'd0) ? 8'd1 : nf_q;
  assign last_frame = ({1'b0, frame_cnt} + 9'd1) >= {1'b0, nf_eff};
  assign h_wr_ok    = wr_en && !wr_sel && (state == IDLE) && (wr_addr < AW'(I));
  assign a_wr_ok    = wr_en &&  wr_sel && (state == IDLE) && (wr_addr < AW'(A));

  always_comb begin
    state_nx = state;
    h_go     = 1'b0;
    a_go     = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx = mode_par ? PAR_SEND : H_SEND;
        h_go     = 1'b1;
        a_go     = mode_par;
      end
      H_SEND: if (h_fin) begin
        state_nx = A_SEND;
        a_go     = 1'b1;
      end
      A_SEND: if (a_fin) state_nx = FRAME_END;
      // A stream whose tvalid is already low has finished its frame
      PAR_SEND: if ((!h_tvalid || h_fin) && (!a_tvalid || a_fin)) state_nx = FRAME_END;
      FRAME_END: if (last_frame) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end else begin
        state_nx = par_q ? PAR_SEND : H_SEND;
        h_go     = 1'b1;
        a_go     = par_q;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      par_q     <= 1'b0;
      nf_q      <= 8'd0;
      frame_cnt <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= done_nx;
      if (start_ok) begin
        par_q     <= mode_par;
        nf_q      <= n_frames;
        frame_cnt <= 8'd0;
      end else if (state == FRAME_END) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < I; i++) h_buf[i] <= '0;
      for (int i = 0; i < A; i++) a_buf[i] <= '0;
      wr_err <= 1'b0;
    end else begin
      if (h_wr_ok) h_buf[wr_addr[HIW-1:0]] <= wr_data[J-1:0];
      if (a_wr_ok) a_buf[wr_addr[AIW-1:0]] <= wr_data;
      if (wr_en && !h_wr_ok && !a_wr_ok) wr_err <= 1'b1;
      else if (start_ok)                 wr_err <= 1'b0;
    end
  end

  // Data is preloaded one beat ahead so the stream outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_data <= '0;
      a_data <= '0;
    end else begin
      if (h_go) h_data <= h_buf[0];
      else if (h_tvalid && strm.H_row_tready) h_data <= h_tlast ? '0 : h_buf[h_idx + 1'b1];
      if (a_go) a_data <= a_buf[0];
      else if (a_tvalid && strm.alpha_u_col_tready) a_data <= a_tlast ? '0 : a_buf[a_idx + 1'b1];
    end
  end

  stream_beat_ctr #(.DEPTH(I)) u_h_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (h_go),
    .tready (strm.H_row_tready),
    .idx    (h_idx),
    .tvalid (h_tvalid),
    .tlast  (h_tlast),
    .fin    (h_fin)
  );

  stream_beat_ctr #(.DEPTH(A)) u_a_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (a_go),
    .tready (strm.alpha_u_col_tready),
    .idx    (a_idx),
    .tvalid (a_tvalid),
    .tlast  (a_tlast),
    .fin    (a_fin)
  );

  assign strm.H_row              = h_data;
  assign strm.H_row_tvalid       = h_tvalid;
  assign strm.H_row_tlast        = h_tlast;
  assign strm.alpha_u_col        = a_data;
  assign strm.alpha_u_col_tvalid = a_tvalid;
  assign strm.alpha_u_col_tlast  = a_tlast;

endmodule

// File: tb/tb_hmat_alpha_stream_src.sv
// tb/tb_hmat_alpha_stream_src.sv - scoreboard bench for hmat_alpha_stream_src
module tb_hmat_alpha_stream_src;
  import hmat_alpha_stream_src_pkg::*;

  localparam int J = 14, I = 7, A = 2, W = 8, AW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, mode_par = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [J*W-1:0] wr_data = '0;
  logic [7:0] n_frames = '0;
  logic wr_err, busy, done;
  logic h_rdy = 1'b1, a_rdy = 1'b1;
  bit bp_en = 1'b0;

  hmat_alpha_stream_src_if #(.J(J), .W(W)) sif ();
  assign sif.H_row_tready       = h_rdy;
  assign sif.alpha_u_col_tready = a_rdy;

  hmat_alpha_stream_src #(.J(J), .I(I), .A(A), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .start(start), .mode_par(mode_par),
    .n_frames(n_frames), .busy(busy), .done(done), .strm(sif.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, start_cyc = 0;
  int h_first, h_last, a_first, a_last, done_cyc, n_done, a_beat;
  logic [J-1:0]   h_mdl [I];
  logic [J*W-1:0] a_mdl [A];
  logic [J*W-1:0] a_seen [A];
  logic [127:0] hq[$], aq[$];
  logic h_stall = 1'b0, a_stall = 1'b0;
  logic [127:0] h_prev, a_prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      h_rdy = ($urandom_range(0, 2) != 0);
      a_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Stream monitor: hold checks under backpressure, scoreboard pops on each beat
  always @(negedge clk) begin
    if (!rst_n) begin
      h_stall = 1'b0;
      a_stall = 1'b0;
    end else begin
      if (h_stall) check("h_hold", 128'({sif.H_row_tvalid, sif.H_row_tlast, sif.H_row}), h_prev);
      if (a_stall) check("a_hold", 128'({sif.alpha_u_col_tvalid, sif.alpha_u_col_tlast, sif.alpha_u_col}), a_prev);
      h_stall = sif.H_row_tvalid && !h_rdy;
      a_stall = sif.alpha_u_col_tvalid && !a_rdy;
      h_prev  = 128'({1'b1, sif.H_row_tlast, sif.H_row});
      a_prev  = 128'({1'b1, sif.alpha_u_col_tlast, sif.alpha_u_col});
      if (sif.H_row_tvalid && h_rdy) begin
        if (h_first < 0) h_first = cyc - start_cyc + 1;
        if (sif.H_row_tlast) h_last = cyc - start_cyc + 1;
        if (hq.size() == 0) check("h_q_size", 128'(hq.size()), 128'(1));
        else check("h_beat", 128'({sif.H_row_tlast, sif.H_row}), hq.pop_front());
      end
      if (sif.alpha_u_col_tvalid && a_rdy) begin
        if (a_first < 0) a_first = cyc - start_cyc + 1;
        if (sif.alpha_u_col_tlast) a_last = cyc - start_cyc + 1;
        a_seen[a_beat % A] = sif.alpha_u_col;
        a_beat++;
        if (aq.size() == 0) check("a_q_size", 128'(aq.size()), 128'(1));
        else check("a_beat", 128'({sif.alpha_u_col_tlast, sif.alpha_u_col}), aq.pop_front());
      end
      if (done) begin
        n_done++;
        done_cyc = cyc - start_cyc + 1;
        check("done_busy", 128'(busy), 128'(0));
      end
    end
  end

  task automatic wr(input bit sel, input int addr, input logic [J*W-1:0] d, input bit ok);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (ok && !sel) h_mdl[addr] = d[J-1:0];
    if (ok && sel)  a_mdl[addr] = d;
  endtask

  task automatic do_start(input bit par, input int nf);
    int eff;
    eff = (nf == 0) ? 1 : nf;
    for (int f = 0; f < eff; f++) begin
      for (int r = 0; r < I; r++) hq.push_back(128'({r == I - 1, h_mdl[r]}));
      for (int c = 0; c < A; c++) aq.push_back(128'({c == A - 1, a_mdl[c]}));
    end
    h_first = -1; h_last = -1; a_first = -1; a_last = -1;
    done_cyc = -1; n_done = 0; a_beat = 0;
    mode_par = par; n_frames = 8'(nf); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check({tag, "_done"}, 128'(done), 128'(1));
    @(posedge clk); #1;
    check({tag, "_hq_empty"}, 128'(hq.size()), 128'(0));
    check({tag, "_aq_empty"}, 128'(aq.size()), 128'(0));
    check({tag, "_n_done"}, 128'(n_done), 128'(1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_h"}, 128'({sif.H_row, sif.H_row_tvalid, sif.H_row_tlast}), 128'(0));
    check({tag, "_a"}, 128'({sif.alpha_u_col, sif.alpha_u_col_tvalid, sif.alpha_u_col_tlast}), 128'(0));
    check({tag, "_ctl"}, 128'({wr_err, busy, done}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [J-1:0] rows [I];
    logic [J*W-1:0] col;
    rows = '{14'h18A3, 14'h0D4A, 14'h14C5, 14'h230B, 14'h22B4, 14'h2538, 14'h1A54};
    for (int i = 0; i < I; i++) h_mdl[i] = '0;
    for (int i = 0; i < A; i++) a_mdl[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < I; r++) wr(1'b0, r, (J*W)'(rows[r]), 1'b1);
    for (int c = 0; c < A; c++) begin
      for (int e = 0; e < J; e++)
        col[(J-1-e)*W +: W] = (e == 0) ? ((c == 0) ? 8'h74 : 8'h8B) : 8'(e * 37 + c * 11 + 5);
      wr(1'b1, c, col, 1'b1);
    end

    // full throughput sequential
    do_start(1'b0, 1);
    wait_done("seq");
    check("seq_h_first", 128'(h_first), 128'(1));
    check("seq_h_last", 128'(h_last), 128'(7));
    check("seq_a_first", 128'(a_first), 128'(8));
    check("seq_a_last", 128'(a_last), 128'(9));
    check("seq_done_cyc", 128'(done_cyc), 128'(11));
    check("seq_col0_msb", 128'(a_seen[0][J*W-1 -: W]), 128'(8'h74));
    check("seq_col1_msb", 128'(a_seen[1][J*W-1 -: W]), 128'(8'h8B));

    // random backpressure, both orderings
    for (int m = 0; m < 2; m++) begin
      bp_en = 1'b1;
      do_start(m[0], 2);
      wait_done(m == 0 ? "bp_seq" : "bp_par");
      bp_en = 1'b0;
      @(posedge clk); #1;
      h_rdy = 1'b1; a_rdy = 1'b1;
    end

    // concurrent
    do_start(1'b1, 1);
    wait_done("par");
    check("par_h_first", 128'(h_first), 128'(1));
    check("par_a_first", 128'(a_first), 128'(1));
    check("par_a_last", 128'(a_last), 128'(2));
    check("par_h_last", 128'(h_last), 128'(7));
    check("par_done_cyc", 128'(done_cyc), 128'(9));

    // repeat
    do_start(1'b0, 3);
    wait_done("rep3");
    check("rep3_done_cyc", 128'(done_cyc), 128'(31));
    do_start(1'b0, 0);
    wait_done("rep0");
    check("rep0_done_cyc", 128'(done_cyc), 128'(11));

    // write errors
    h_rdy = 1'b0;
    do_start(1'b0, 1);
    wr(1'b0, 0, '1, 1'b0);
    check("err_busy", 128'(wr_err), 128'(1));
    h_rdy = 1'b1;
    wait_done("err_run");
    wr(1'b0, 7, '1, 1'b0);
    wr(1'b1, 2, '1, 1'b0);
    check("err_addr", 128'(wr_err), 128'(1));
    do_start(1'b0, 1);
    check("err_clear", 128'(wr_err), 128'(0));
    wait_done("err_after");

    // reset during H row 3
    do_start(1'b0, 1);
    repeat (4) @(negedge clk);
    check("mid_row3", 128'(sif.H_row), 128'(h_mdl[3]));
    #1 rst_n = 1'b0;
    #1 check_zero("mid_rst");
    hq.delete(); aq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < I; i++) h_mdl[i] = '0;
    for (int i = 0; i < A; i++) a_mdl[i] = '0;
    @(posedge clk); #1;
    do_start(1'b0, 1);
    wait_done("post_rst");
    check("post_rst_done_cyc", 128'(done_cyc), 128'(11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hmat_alpha_stream_src.md
# hmat_alpha_stream_src

Parametrised, reloadable stimulus source for the decoder core. It holds an I×J parity-check matrix (one row per beat) and A alpha columns of J signed W-bit values in register buffers, and streams them into the core's `H_row` and `alpha_u_col` AXI-stream-style inputs. The stream side honours `tready` backpressure, repeats whole frames a programmable number of times, and offers sequential or concurrent ordering of the two streams. It replaces hard-coded per-case stimulus drivers in test tops and bring-up builds.

## Interface
- `J`, 14, row width / number of variable nodes
- `I`, 7, number of H rows
- `A`, 2, number of alpha columns
- `W`, 8, alpha element width in bits
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `wr_en`  in  1  buffer write strobe
- `wr_sel`  in  1  0 = H buffer, 1 = alpha buffer
- `wr_addr`  in  AW = $clog2(max(I,A))+1  row or column index
- `wr_data`  in  J*W  write data; H writes use bits [J-1:0]
- `wr_err`  out  1  sticky flag; write rejected for busy state or out-of-range address; cleared by `start`
- `start`  in  1  begin streaming; sampled in IDLE only
- `mode_par`  in  1  0 = H then alpha; 1 = both streams concurrently; latched at `start`
- `n_frames`  in  8  frame repeat count; 0 is treated as 1; latched at `start`
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle pulse after the final frame
- `H_row`  out  J  row data
- `H_row_tvalid`, `H_row_tlast`  out  1  stream controls; `tlast` is asserted on row I-1
- `H_row_tready`  in  1  sink ready
- `alpha_u_col`  out  J*W  column data; element 0 is in the MSBs
- `alpha_u_col_tvalid`, `alpha_u_col_tlast`  out  1  stream controls; `tlast` is asserted on column A-1
- `alpha_u_col_tready`  in  1  sink ready

## Operation
- States: IDLE, H_SEND, A_SEND, PAR_SEND, FRAME_END.
- **Reset values:**
  - All outputs are 0.
  - Both buffers are cleared to 0.
  - Counters are 0 and the state is IDLE.
- **Writes:**
  - A write is accepted only in IDLE with a valid address: `wr_addr`<I for H, `wr_addr`<A for alpha.
  - Any other write is ignored and sets `wr_err`.
- **Start:** `start` in IDLE does the following:
  - Latches `mode_par` and `n_frames`.
  - Clears `wr_err` and the frame counter.
  - Enters H_SEND (sequential) or PAR_SEND (concurrent).
  - `start` while busy is ignored.
- **Beat rule:**
  - A beat transfers when `tvalid && tready` on the same edge.
  - While `tvalid && !tready`, data and `tlast` hold stable.
  - `tvalid` never drops before its handshake completes.
- **H_SEND:**
  - Present row r = 0..I-1.
  - After the handshake on row I-1, go to A_SEND. The alpha stream asserts `tvalid` on the next cycle.
- **A_SEND:**
  - Present column c = 0..A-1.
  - After the handshake on column A-1, go to FRAME_END.
- **PAR_SEND:**
  - The two streams run on independent counters, each honouring its own `tready`.
  - Each stream drops `tvalid` after its own last beat.
  - Go to FRAME_END when both streams have completed.
- **FRAME_END:** this state lasts 1 cycle, with both `tvalid` low.
  - The frame counter increments.
  - If frames < max(`n_frames`,1), restart at row 0 / column 0 in the latched mode.
  - Otherwise pulse `done` and return to IDLE.
- **Reset mid-stream:** all outputs and buffers return to reset values at once. No partial frame resumes.

## Timing
- **Start:** `start` sampled at edge k gives `tvalid`=1 with row 0 (or column 0 too, in PAR mode) from k+1.
- **Full throughput:** with `tready` held high, one beat per cycle.
  - Sequential frame: I + A + 1 cycles.
  - Concurrent frame: max(I,A) + 1 cycles.
- **done:** asserted in the cycle after FRAME_END of the last frame; `busy` falls in the same cycle.
- **Outputs:** all outputs are registered; no combinational path from `tready` to any output.

## Structure
- Shared package holds:
  - State enum.
  - AW computation.
  - Default J/I/A/W constants shared with the core.
- One sub-module, `stream_beat_ctr`, instanced twice (H and alpha). It contains:
  - Index counter, valid/last registers and hold-under-backpressure logic.
  - Parameters: `DEPTH`.
  - Ports: `go`, `tready`, `idx`, `tvalid`, `tlast`, `fin`.

## Test plan
- **Load and stream, full throughput:** load H rows 0x18A3, 0x0D4A, 0x14C5, 0x230B, 0x22B4, 0x2538, 0x1A54, load both alpha columns, `start` with `n_frames`=1, `tready`=1.
  - Required: 7 H beats in consecutive cycles, `tlast` only on 0x1A54.
  - Required: then 2 alpha beats, with column 0 MSB byte 0x74 and column 1 MSB byte 0x8B.
  - Required: `done` at cycle 11 after `start`.
- **Backpressure:** random `tready` on both streams.
  - Required: data is never altered while `tvalid` is high and `tready` is low.
  - Required: beat order and count are unchanged.
- **Concurrent mode:** `mode_par`=1, I=7, A=2.
  - Required: both `tvalid` rise together.
  - Required: alpha `tlast` on cycle 2, H `tlast` on cycle 7, `done` 1 cycle after FRAME_END.
- **Repeat:** `n_frames`=3.
  - Required: 3 identical frames, each separated by 1 idle cycle, and a single `done` pulse.
  - With `n_frames`=0: exactly 1 frame.
- **Write errors:** write while busy, and write to H at address 7.
  - Required: buffer contents unchanged and `wr_err`=1.
  - Required: the next `start` clears `wr_err`.
- **Reset mid-stream:** assert `rst_n`=0 during H row 3.
  - Required: all outputs go to 0 immediately.
  - Required: after release, `start` streams all-zero rows (buffers cleared).
